m65c02_psw_wb: RTL

- Result writeback and processor status stage that sits directly downstream of the M65C02 adder.
- Consumes the adder's Out/OV/Val outputs and writes A, X or Y.
- Maintains the P register (N V 1 B D I Z C), including the extra cycle of latency on the decimal path.
- Also applies explicit flag operations (SEC/CLC/SED/CLD/SEI/CLI/CLV) and P loads (PLP/RTI).

---
 rtl/m65c02_psw_wb_pkg.sv | 38 +++
 rtl/m65c02_psw_wb_if.sv | 30 +++
 rtl/m65c02_psw_wb_flag_mux.sv | 46 ++++
 rtl/m65c02_psw_wb.sv | 109 ++++++++++
 4 files changed

// File: rtl/m65c02_psw_wb_pkg.sv
// Shared encodings for the M65C02 writeback / status stage: P bit positions,
// writeback targets, flag-op codes and the update-mask layout.
package m65c02_pkg;

  localparam int PSW_N = 7;
  localparam int PSW_V = 6;
  localparam int PSW_5 = 5;
  localparam int PSW_B = 4;
  localparam int PSW_D = 3;
  localparam int PSW_I = 2;
  localparam int PSW_Z = 1;
  localparam int PSW_C = 0;

  localparam int UPD_NZ = 2;
  localparam int UPD_V  = 1;
  localparam int UPD_C  = 0;

  localparam logic [7:0] P_RST_DEF = 8'h34;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_A    = 2'd1,
    DST_X    = 2'd2,
    DST_Y    = 2'd3
  } dst_e;

  typedef enum logic [2:0] {
    FLG_NOP = 3'd0,
    FLG_CLC = 3'd1,
    FLG_SEC = 3'd2,
    FLG_CLI = 3'd3,
    FLG_SEI = 3'd4,
    FLG_CLD = 3'd5,
    FLG_SED = 3'd6,
    FLG_CLV = 3'd7
  } flg_e;

endpackage

// File: rtl/m65c02_psw_wb_if.sv
// Decoder/adder-facing bundle of the writeback stage: issue controls, adder
// result, flag/P-load controls, and the architectural register outputs.
interface m65c02_psw_wb_if;
  logic       En_AU;
  logic       En_DU;
  logic [1:0] Dst;
  logic [2:0] Upd;
  logic [8:0] Sum;
  logic       OV;
  logic       Val;
  logic [2:0] Flg_Op;
  logic       Ld_P;
  logic [7:0] DI;
  logic [7:0] A;
  logic [7:0] X;
  logic [7:0] Y;
  logic [7:0] P;
  logic       Busy;
  logic       Err;

  modport master (
    output En_AU, En_DU, Dst, Upd, Sum, OV, Val, Flg_Op, Ld_P, DI,
    input  A, X, Y, P, Busy, Err
  );

  modport slave (
    input  En_AU, En_DU, Dst, Upd, Sum, OV, Val, Flg_Op, Ld_P, DI,
    output A, X, Y, P, Busy, Err
  );
endinterface

// File: rtl/m65c02_psw_wb_flag_mux.sv
// Next-P merge. Sources are layered lowest priority first so each bit ends up
// owned by the strongest source that touches it: Flg_Op, then writeback, then Ld_P.
module m65c02_flag_mux
  import m65c02_pkg::*;
(
  input  logic [7:0] p_cur,
  input  logic       ld_p,
  input  logic [7:0] di,
  input  logic       wb_en,
  input  logic [2:0] wb_upd,
  input  logic [8:0] wb_sum,
  input  logic       wb_ov,
  input  logic [2:0] flg_op,
  output logic [7:0] p_nxt
);

  always_comb begin
    p_nxt = p_cur;
    case (flg_op)
      FLG_CLC: p_nxt[PSW_C] = 1'b0;
      FLG_SEC: p_nxt[PSW_C] = 1'b1;
      FLG_CLI: p_nxt[PSW_I] = 1'b0;
      FLG_SEI: p_nxt[PSW_I] = 1'b1;
      FLG_CLD: p_nxt[PSW_D] = 1'b0;
      FLG_SED: p_nxt[PSW_D] = 1'b1;
      FLG_CLV: p_nxt[PSW_V] = 1'b0;
      default: p_nxt = p_cur;
    endcase

    if (wb_en) begin
      if (wb_upd[UPD_NZ]) begin
        p_nxt[PSW_N] = wb_sum[7];
        p_nxt[PSW_Z] = (wb_sum[7:0] == 8'h00);
      end
      if (wb_upd[UPD_V]) p_nxt[PSW_V] = wb_ov;
      if (wb_upd[UPD_C]) p_nxt[PSW_C] = wb_sum[8];
    end

    if (ld_p) p_nxt = di;

    // Bits 5 and B have no storage meaning here; they always read as 1.
    p_nxt[PSW_5] = 1'b1;
    p_nxt[PSW_B] = 1'b1;
  end

endmodule

// File: rtl/m65c02_psw_wb.sv
// M65C02 result writeback and status stage: A/X/Y file, P register, one-deep
// pending slot for the decimal adder's extra cycle, and sticky protocol error.
module m65c02_psw_wb
  import m65c02_pkg::*;
#(
  parameter logic [7:0] P_RST   = P_RST_DEF,
  parameter logic [7:0] REG_RST = 8'h00
)(
  input  logic             Clk,
  input  logic             Rst,
  m65c02_psw_wb_if.slave   bus
);

  logic [7:0] a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d;
  logic       busy_q, busy_d, err_q, err_d;
  logic [1:0] pdst_q, pdst_d;
  logic [2:0] pupd_q, pupd_d;

  logic       bin_iss, dec_iss, wb_exp, wb_en;
  logic [1:0] wb_dst;
  logic [2:0] wb_upd;

  always_comb begin
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    err_d   = err_q;
    pdst_d  = pdst_q;
    pupd_d  = pupd_q;
    wb_exp  = 1'b0;
    wb_dst  = bus.Dst;
    wb_upd  = bus.Upd;
    bin_iss = bus.En_AU & ~bus.En_DU;
    dec_iss = bus.En_DU & ~bus.En_AU;

    // While a decimal result is pending, this cycle belongs to it; any new
    // issue is a decoder bug and is dropped.
    if (busy_q) begin
      wb_exp = 1'b1;
      wb_dst = pdst_q;
      wb_upd = pupd_q;
      busy_d = 1'b0;
      pdst_d = 2'd0;
      pupd_d = 3'd0;
      if (bin_iss || dec_iss) err_d = 1'b1;
    end else if (bin_iss) begin
      wb_exp = 1'b1;
    end else if (dec_iss) begin
      pdst_d = bus.Dst;
      pupd_d = bus.Upd;
      busy_d = 1'b1;
    end

    wb_en = wb_exp & bus.Val;
    if (wb_exp && !bus.Val) err_d = 1'b1;

    if (wb_en) begin
      case (wb_dst)
        DST_A:   a_d = bus.Sum[7:0];
        DST_X:   x_d = bus.Sum[7:0];
        DST_Y:   y_d = bus.Sum[7:0];
        default: a_d = a_q;
      endcase
    end
  end

  m65c02_flag_mux u_flag_mux (
    .p_cur  (p_q),
    .ld_p   (bus.Ld_P),
    .di     (bus.DI),
    .wb_en  (wb_en),
    .wb_upd (wb_upd),
    .wb_sum (bus.Sum),
    .wb_ov  (bus.OV),
    .flg_op (bus.Flg_Op),
    .p_nxt  (p_d)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q    <= REG_RST;
      x_q    <= REG_RST;
      y_q    <= REG_RST;
      p_q    <= P_RST;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      pdst_q <= 2'd0;
      pupd_q <= 3'd0;
    end else begin
      a_q    <= a_d;
      x_q    <= x_d;
      y_q    <= y_d;
      p_q    <= p_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      pdst_q <= pdst_d;
      pupd_q <= pupd_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.X    = x_q;
  assign bus.Y    = y_q;
  assign bus.P    = p_q;
  assign bus.Busy = busy_q;
  assign bus.Err  = err_q;

endmodule
